// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of a five-stage MIPS pipeline. It holds the program
// counter, selects the next PC, and owns the IF/ID pipeline register.
//
// Each cycle the first matching case below applies:
//   1. reset    : PC goes to RESET_PC and IF/ID is cleared.
//   2. stall    : everything holds.
//   3. redirect : a taken branch or a jump loads the PC with its target,
//                 squashes the wrong-path word and clears the halt state.
//   4. halted   : the PC holds and IF/ID is filled with bubbles.
//   5. normal   : the fetched word enters IF/ID. A halt word freezes the PC.
//
// Ports
//   clk            in   pipeline clock, rising edge
//   reset          in   synchronous active-high reset
//   stall          in   hazard-unit stall; holds PC and IF/ID
//   pc_src         in   branch taken (resolved in ID)
//   branch_target  in   [31:0] branch destination
//   jump           in   unconditional jump (decoded in ID)
//   jump_target    in   [31:0] jump destination
//   imem_addr      out  [31:0] instruction memory address (= PC)
//   imem_rdata     in   [31:0] instruction word, combinational read of imem_addr
//   ifid_instr     out  [31:0] IF/ID instruction
//   ifid_pc_plus4  out  [31:0] IF/ID PC+4
//   ifid_valid     out  IF/ID holds a real instruction
//   halted         out  halt word fetched; PC frozen
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
   parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        pc_src,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc_plus4,
   output logic        ifid_valid,
   output logic        halted
);

   logic [31:0] pc_reg;
   logic [31:0] pc_next;
   logic [31:0] pc_plus4;
   logic [31:0] ifid_instr_reg;
   logic [31:0] ifid_instr_next;
   logic [31:0] ifid_pc_plus4_reg;
   logic [31:0] ifid_pc_plus4_next;
   logic        ifid_valid_reg;
   logic        ifid_valid_next;
   logic        halted_reg;
   logic        halted_next;
   logic        redirect;
   logic [31:0] redirect_target;

   // The addition wraps modulo 2^32: a PC of FFFF_FFFC continues at 0.
   assign pc_plus4        = pc_reg + 32'd4;
   assign redirect        = pc_src | jump;
   // A taken branch has priority over a jump when both are asserted.
   assign redirect_target = pc_src ? branch_target : jump_target;

   always_comb begin
      pc_next            = pc_reg;
      ifid_instr_next    = ifid_instr_reg;
      ifid_pc_plus4_next = ifid_pc_plus4_reg;
      ifid_valid_next    = ifid_valid_reg;
      halted_next        = halted_reg;

      // During a stall the branch operands are not valid yet, so the redirect
      // inputs are ignored and every register keeps its value.
      if (!stall) begin
         if (redirect) begin
            // The word fetched this cycle is on the wrong path. This holds
            // even if it is a halt word, so the halt state is cleared.
            pc_next            = redirect_target;
            ifid_instr_next    = NOP_INSTR;
            ifid_pc_plus4_next = 32'd0;
            ifid_valid_next    = 1'b0;
            halted_next        = 1'b0;
         end else if (halted_reg) begin
            // Keep sending bubbles so the rest of the pipeline can drain.
            ifid_instr_next    = NOP_INSTR;
            ifid_pc_plus4_next = 32'd0;
            ifid_valid_next    = 1'b0;
         end else begin
            // imem_rdata is read only here, so an undefined word during a
            // stall, redirect or halt never reaches IF/ID.
            ifid_instr_next    = imem_rdata;
            ifid_pc_plus4_next = pc_plus4;
            ifid_valid_next    = 1'b1;
            if (imem_rdata == HALT_INSTR) begin
               halted_next = 1'b1;
            end else begin
               pc_next = pc_plus4;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_reg            <= RESET_PC;
         ifid_instr_reg    <= NOP_INSTR;
         ifid_pc_plus4_reg <= 32'd0;
         ifid_valid_reg    <= 1'b0;
         halted_reg        <= 1'b0;
      end else begin
         pc_reg            <= pc_next;
         ifid_instr_reg    <= ifid_instr_next;
         ifid_pc_plus4_reg <= ifid_pc_plus4_next;
         ifid_valid_reg    <= ifid_valid_next;
         halted_reg        <= halted_next;
      end
   end

   assign imem_addr     = pc_reg;
   assign ifid_instr    = ifid_instr_reg;
   assign ifid_pc_plus4 = ifid_pc_plus4_reg;
   assign ifid_valid    = ifid_valid_reg;
   assign halted        = halted_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// This is a scoreboard testbench for fetch_stage.
//
// The stimulus task drives one cycle of inputs at each falling edge. It then
// advances a behavioural model of the stage and pushes the expected
// post-edge state into a queue. A separate monitor process pops that queue
// after every rising edge and compares the entry against the DUT.
//
// The instruction memory is a function of the address. An address that is
// listed in halt_a0 or halt_a1 returns the halt word. Any other address
// returns {addr[29:0], 2'b01}, which can never equal the halt word.
//
// In the cases where the stage must ignore imem_rdata (stall, halted without
// redirect, and reset), the bench drives a garbage word on imem_rdata
// instead. That garbage word is often the halt word itself.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] HALT   = 32'hFFFF_FFFF;
   localparam logic [31:0] NOP    = 32'h0000_0000;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        pc_src = 1'b0;
   logic        jump = 1'b0;
   logic [31:0] branch_target = '0;
   logic [31:0] jump_target = '0;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc_plus4;
   logic        ifid_valid;
   logic        halted;

   always #5 clk = ~clk;

   fetch_stage #(
      .RESET_PC  (RST_PC),
      .NOP_INSTR (NOP),
      .HALT_INSTR(HALT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .pc_src       (pc_src),
      .branch_target(branch_target),
      .jump         (jump),
      .jump_target  (jump_target),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .ifid_instr   (ifid_instr),
      .ifid_pc_plus4(ifid_pc_plus4),
      .ifid_valid   (ifid_valid),
      .halted       (halted)
   );

   // Instruction memory, plus garbage injection for the cycles where the
   // stage must not sample imem_rdata.
   logic        use_garbage = 1'b1;
   logic [31:0] garbage_word = 32'hDEAD_BEEF;
   logic [31:0] halt_a0 = 32'h0000_0003;
   logic [31:0] halt_a1 = 32'h0000_0007;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == halt_a0 || a == halt_a1) return HALT;
      return {a[29:0], 2'b01};
   endfunction

   assign imem_rdata = use_garbage ? garbage_word : mem_word(imem_addr);

   // Behavioural model state.
   logic [31:0] m_pc = RST_PC;
   logic [31:0] m_instr = NOP;
   logic [31:0] m_pc4 = 32'd0;
   logic        m_valid = 1'b0;
   logic        m_halted = 1'b0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic        halted;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   txn = 0;

   // Drive one cycle of inputs, advance the model, and queue the expected
   // state that the DUT must show after the next rising edge.
   task automatic cycle(input logic r, input logic s, input logic ps,
                        input logic [31:0] bt, input logic j,
                        input logic [31:0] jt);
      exp_t        e;
      logic [31:0] w;
      @(negedge clk);
      reset         = r;
      stall         = s;
      pc_src        = ps;
      branch_target = bt;
      jump          = j;
      jump_target   = jt;
      use_garbage   = r || s || (!ps && !j && m_halted);
      garbage_word  = ($urandom_range(0, 1) == 1) ? HALT : $urandom();

      if (r) begin
         m_pc = RST_PC; m_instr = NOP; m_pc4 = 0; m_valid = 0; m_halted = 0;
      end else if (s) begin
         // everything holds
      end else if (ps || j) begin
         m_pc = ps ? bt : jt;
         m_instr = NOP; m_pc4 = 0; m_valid = 0; m_halted = 0;
      end else if (m_halted) begin
         m_instr = NOP; m_pc4 = 0; m_valid = 0;
      end else begin
         w = mem_word(m_pc);
         m_instr = w; m_pc4 = m_pc + 32'd4; m_valid = 1;
         if (w == HALT) m_halted = 1;
         else m_pc = m_pc + 32'd4;
      end

      e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4;
      e.valid = m_valid; e.halted = m_halted;
      exp_q.push_back(e);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle(0, 0, 0, 32'h0, 0, 32'h0);
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL txn %0d %s: got %h expected %h", txn, name, act, want);
      end
   endtask

   // Monitor: pop one expected entry after each rising edge.
   exp_t got;
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         got = exp_q.pop_front();
         $display("txn %0d: rst=%b stall=%b ps=%b j=%b pc=%h instr=%h pc4=%h v=%b h=%b",
                  txn, reset, stall, pc_src, jump, imem_addr, ifid_instr,
                  ifid_pc_plus4, ifid_valid, halted);
         chk("imem_addr", imem_addr, got.pc);
         chk("ifid_instr", ifid_instr, got.instr);
         chk("ifid_pc_plus4", ifid_pc_plus4, got.pc4);
         chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, got.valid});
         chk("halted", {31'd0, halted}, {31'd0, got.halted});
         txn++;
      end
   end

   function automatic logic [31:0] pick_target();
      case ($urandom_range(0, 4))
         0:       return 32'h0000_0040;
         1:       return 32'h0000_0044;
         2:       return 32'hFFFF_FFF4;
         3:       return $urandom() & 32'hFFFF_FFFC;
         default: return 32'h0000_0008;
      endcase
   endfunction

   initial begin
      // Reset, free run, then a taken branch at PC=8.
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      run(2);
      cycle(0, 0, 1, 32'h40, 0, 0);
      run(2);

      // A stall holds back a branch; the branch resolves once the stall drops.
      cycle(1, 0, 0, 0, 0, 0);
      run(4);
      cycle(0, 1, 1, 32'h999, 0, 0);
      cycle(0, 1, 1, 32'h999, 0, 0);
      cycle(0, 0, 1, 32'h80, 0, 0);
      run(1);

      // Halt at 0x0C, followed by ten bubbles.
      halt_a0 = 32'h0C;
      cycle(1, 0, 0, 0, 0, 0);
      run(3);
      run(11);
      // A redirect while halted resumes fetch. The run then halts at 0x48,
      // and a reset arrives mid-halt.
      halt_a1 = 32'h48;
      cycle(0, 0, 1, 32'h40, 0, 0);
      run(6);
      cycle(1, 0, 0, 0, 0, 0);
      run(1);

      // A halt word fetched in the same cycle as a jump is squashed.
      cycle(1, 0, 0, 0, 0, 0);
      run(3);
      cycle(0, 0, 0, 0, 1, 32'h20);
      run(2);

      // A taken branch and a jump together: the branch wins.
      cycle(0, 0, 1, 32'h100, 1, 32'h200);
      run(1);

      // The PC wraps from FFFF_FFFC to 0.
      cycle(0, 0, 0, 0, 1, 32'hFFFF_FFF8);
      run(3);

      // Reset dominates a stall.
      cycle(0, 0, 0, 0, 1, 32'h30);
      cycle(1, 1, 1, 32'h50, 0, 0);
      run(1);

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 99) < 2,
               $urandom_range(0, 99) < 20,
               $urandom_range(0, 99) < 10, pick_target(),
               $urandom_range(0, 99) < 10, pick_target());
      end
      cycle(0, 0, 0, 0, 0, 0);

      // Drain the scoreboard with a bounded wait.
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
